// File: rtl/cpu_pkg.sv
// Shared RV32I core constants: datapath width, reset vector, canonical NOP,
// base opcodes and the fetch-stage state encoding.
package cpu_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Skid register for the SRAM read data while decode is stalled, plus the
// mux that picks what decode actually sees on if_inst.
module fetch_hold_buf
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INST_P = cpu_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        drop,
  input  logic        if_valid,
  input  logic [31:0] im_dout,
  output logic [31:0] if_inst
);

  logic        hold_vld_q;
  logic        hold_vld_d;
  logic [31:0] hold_inst_q;
  logic [31:0] hold_inst_d;

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_inst_d = hold_inst_q;
    if (drop) begin
      hold_vld_d = 1'b0;
    end else if (capture) begin
      hold_vld_d  = 1'b1;
      hold_inst_d = im_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_inst_q <= NOP_INST_P;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // Once captured, the SRAM output belongs to the re-read of pc_f, not to if_pc.
  assign if_inst = !if_valid  ? NOP_INST_P  :
                   hold_vld_q ? hold_inst_q : im_dout;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC generation, synchronous I-mem interface and
// the IF/ID register, with stall hold and EX redirect squash.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int          XLEN     = cpu_pkg::XLEN,
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  output logic            im_cs,
  output logic [XLEN-1:0] im_addr,
  input  logic [31:0]     im_dout,
  input  logic            id_stall,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_valid
);

  localparam logic [XLEN-1:0] PC_RST  = RESET_PC[XLEN-1:0];
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_M = ~XLEN'(3);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_f_q;
  logic [XLEN-1:0] pc_f_d;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_pc_d;
  logic            if_valid_q;
  logic            if_valid_d;
  logic            hold_capture;
  logic            hold_drop;

  // Next-state / next-PC selection: redirect beats stall beats advance.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    if_pc_d      = if_pc_q;
    if_valid_d   = if_valid_q;
    hold_capture = 1'b0;
    hold_drop    = 1'b0;
    if (ex_redirect) begin
      pc_f_d     = ex_target & ALIGN_M;
      if_valid_d = 1'b0;
      hold_drop  = 1'b1;
      state_d    = BOOT;
    end else begin
      unique case (state_q)
        BOOT: begin
          if (!id_stall) begin
            if_pc_d    = pc_f_q;
            pc_f_d     = pc_f_q + PC_STEP;
            if_valid_d = 1'b1;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (id_stall) begin
            hold_capture = 1'b1;
            state_d      = HOLD;
          end else begin
            if_pc_d    = pc_f_q;
            pc_f_d     = pc_f_q + PC_STEP;
            if_valid_d = 1'b1;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            if_pc_d    = pc_f_q;
            pc_f_d     = pc_f_q + PC_STEP;
            if_valid_d = 1'b1;
            hold_drop  = 1'b1;
            state_d    = RUN;
          end
        end
        default: begin
          if_valid_d = 1'b0;
          hold_drop  = 1'b1;
          state_d    = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_f_q     <= PC_RST;
      if_pc_q    <= PC_RST;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  fetch_hold_buf #(
    .NOP_INST_P (NOP_INST)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .capture  (hold_capture),
    .drop     (hold_drop),
    .if_valid (if_valid_q),
    .im_dout  (im_dout),
    .if_inst  (if_inst)
  );

  assign im_cs    = ~rst;
  assign im_addr  = pc_f_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, stall hold, redirect, redirect+stall,
// PC wrap (second instance with a high reset vector) and reset during HOLD.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_cs;
  logic [31:0] im_addr;
  logic [31:0] im_dout = 32'h0;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  logic        w_im_cs;
  logic [31:0] w_im_addr;
  logic [31:0] w_im_dout = 32'h0;
  logic        w_id_stall = 1'b0;
  logic        w_ex_redirect = 1'b0;
  logic [31:0] w_ex_target = 32'h0;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_inst;
  logic        w_if_valid;

  logic [31:0] mem [0:255];
  int          n_chk  = 0;
  int          n_fail = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk         (clk),
    .rst         (rst),
    .im_cs       (im_cs),
    .im_addr     (im_addr),
    .im_dout     (im_dout),
    .id_stall    (id_stall),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .im_cs       (w_im_cs),
    .im_addr     (w_im_addr),
    .im_dout     (w_im_dout),
    .id_stall    (w_id_stall),
    .ex_redirect (w_ex_redirect),
    .ex_target   (w_ex_target),
    .if_pc       (w_if_pc),
    .if_inst     (w_if_inst),
    .if_valid    (w_if_valid)
  );

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    if (im_cs) im_dout <= mem[im_addr[9:2]];
  end

  function automatic logic [31:0] word_at(input int idx);
    return 32'hC000_0000 | 32'(idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word_at(i);
    rst = 1'b1; id_stall = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0;
    repeat (3) tick();
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_addr",  im_addr, 32'h0);
    chk("rst_cs",    {31'b0, im_cs}, 32'h0);
    chk("rst_inst",  if_inst, NOP);
    chk("rst_pc",    if_pc, 32'h0);
    chk("rst_waddr", w_im_addr, 32'hFFFF_FFF8);
    rst = 1'b0;
    #1;
    chk("boot_cs",   {31'b0, im_cs}, 32'h1);
    chk("boot_valid",{31'b0, if_valid}, 32'h0);

    // Sequential fetch from reset, plus PC wrap on the second instance
    tick();
    chk("t1_pc0",   if_pc, 32'h0);
    chk("t1_inst0", if_inst, word_at(0));
    chk("t1_valid", {31'b0, if_valid}, 32'h1);
    chk("t1_addr",  im_addr, 32'h4);
    chk("t5_addr1", w_im_addr, 32'hFFFF_FFFC);
    chk("t5_pc1",   w_if_pc, 32'hFFFF_FFF8);
    tick();
    chk("t1_pc4",   if_pc, 32'h4);
    chk("t1_inst1", if_inst, word_at(1));
    chk("t5_addr2", w_im_addr, 32'h0);
    chk("t5_pc2",   w_if_pc, 32'hFFFF_FFFC);
    tick();
    chk("t1_pc8",   if_pc, 32'h8);
    chk("t1_inst2", if_inst, word_at(2));
    chk("t5_addr3", w_im_addr, 32'h4);
    chk("t5_pc3",   w_if_pc, 32'h0);

    // Three-cycle stall at if_pc=8
    id_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_pc",   if_pc, 32'h8);
      chk("t2_inst", if_inst, word_at(2));
      chk("t2_addr", im_addr, 32'hC);
    end
    id_stall = 1'b0;
    tick();
    chk("t2_pc12",   if_pc, 32'hC);
    chk("t2_inst3",  if_inst, word_at(3));
    chk("t2_valid",  {31'b0, if_valid}, 32'h1);

    // Redirect at if_pc=0x10
    tick();
    chk("t3_pc10",   if_pc, 32'h10);
    chk("t3_inst4",  if_inst, word_at(4));
    ex_redirect = 1'b1; ex_target = 32'h40;
    tick();
    chk("t3_addr",   im_addr, 32'h40);
    chk("t3_valid",  {31'b0, if_valid}, 32'h0);
    chk("t3_inst",   if_inst, NOP);
    ex_redirect = 1'b0;
    tick();
    chk("t3_pc40",   if_pc, 32'h40);
    chk("t3_valid1", {31'b0, if_valid}, 32'h1);
    chk("t3_inst16", if_inst, word_at(16));
    chk("t3_addr44", im_addr, 32'h44);

    // Enter HOLD, then redirect together with stall to a misaligned target
    id_stall = 1'b1;
    tick();
    chk("t4_hold_inst", if_inst, word_at(16));
    ex_redirect = 1'b1; ex_target = 32'h82;
    tick();
    chk("t4_addr",  im_addr, 32'h80);
    chk("t4_valid", {31'b0, if_valid}, 32'h0);
    chk("t4_inst",  if_inst, NOP);
    ex_redirect = 1'b0; id_stall = 1'b0;
    tick();
    chk("t4_pc80",   if_pc, 32'h80);
    chk("t4_inst32", if_inst, word_at(32));
    chk("t4_valid1", {31'b0, if_valid}, 32'h1);
    tick();
    chk("t4_pc84",   if_pc, 32'h84);
    chk("t4_inst33", if_inst, word_at(33));

    // Reset asserted while in HOLD
    id_stall = 1'b1;
    tick();
    chk("t6_hold_pc", if_pc, 32'h84);
    rst = 1'b1;
    #1;
    chk("t6_cs0",    {31'b0, im_cs}, 32'h0);
    tick();
    chk("t6_valid",  {31'b0, if_valid}, 32'h0);
    chk("t6_addr",   im_addr, 32'h0);
    chk("t6_inst",   if_inst, NOP);
    chk("t6_cs",     {31'b0, im_cs}, 32'h0);
    rst = 1'b0; id_stall = 1'b0;
    tick();
    chk("t6_pc0",    if_pc, 32'h0);
    chk("t6_inst0",  if_inst, word_at(0));
    chk("t6_valid1", {31'b0, if_valid}, 32'h1);
    chk("t6_addr4",  im_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
